// File: rtl/ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ram_arbiter                                                   |
// | Brief    : Two-port round-robin arbiter/sequencer for one single-port    |
// |            RAM. Optional power-on clear: define RAM_ARB_CLEAR_EN.        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ram_arbiter #(
    parameter int REG_W  = 16,
    parameter int REG_N  = 8,
    parameter int ADDR_W = $clog2(REG_N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [REG_W-1:0]  a_wdata,
    output logic              a_gnt,
    output logic              a_done,
    output logic [REG_W-1:0]  a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [REG_W-1:0]  b_wdata,
    output logic              b_gnt,
    output logic              b_done,
    output logic [REG_W-1:0]  b_rdata,
    output logic [REG_W-1:0]  ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [REG_W-1:0]  ram_out,
    output logic              init_busy
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_access = 2'd1;
`ifdef RAM_ARB_CLEAR_EN
    localparam logic [1:0]        c_st_clear  = 2'd2;
    localparam logic [1:0]        c_st_reset  = c_st_clear;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(REG_N - 1);
`else
    localparam logic [1:0]        c_st_reset  = c_st_idle;
`endif

    logic [1:0]        r_state;
    logic              r_last_b;
    logic              r_sel_b;
    logic              r_cmd_we;
    logic [ADDR_W-1:0] r_cmd_addr;
    logic [REG_W-1:0]  r_cmd_wdata;
    logic              w_pick_b;

    // B wins when it is alone, or when both ask and A was served last.
    assign w_pick_b = b_req & (~a_req | ~r_last_b);

    // The command registers double as the RAM address/data bus, so the bus
    // naturally holds its last value outside ACCESS.
    assign ram_address = r_cmd_addr;
    assign ram_in      = r_cmd_wdata;

`ifdef RAM_ARB_CLEAR_EN
    // Qualified by rst_n so nothing is written while reset is held.
    assign ram_load  = ((r_state == c_st_access) & r_cmd_we) |
                       ((r_state == c_st_clear) & rst_n);
    assign init_busy = (r_state == c_st_clear) & rst_n;
`else
    assign ram_load  = (r_state == c_st_access) & r_cmd_we;
    assign init_busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_st_reset;
            r_last_b    <= 1'b1;
            r_sel_b     <= 1'b0;
            r_cmd_we    <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_wdata <= '0;
            a_gnt       <= 1'b0;
            b_gnt       <= 1'b0;
            a_done      <= 1'b0;
            b_done      <= 1'b0;
            a_rdata     <= '0;
            b_rdata     <= '0;
        end else begin
            a_gnt  <= 1'b0;
            b_gnt  <= 1'b0;
            a_done <= 1'b0;
            b_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (a_req | b_req) begin
                        r_state     <= c_st_access;
                        r_sel_b     <= w_pick_b;
                        r_last_b    <= w_pick_b;
                        a_gnt       <= ~w_pick_b;
                        b_gnt       <= w_pick_b;
                        r_cmd_we    <= w_pick_b ? b_we    : a_we;
                        r_cmd_addr  <= w_pick_b ? b_addr  : a_addr;
                        r_cmd_wdata <= w_pick_b ? b_wdata : a_wdata;
                    end
                end
                c_st_access: begin
                    r_state <= c_st_idle;
                    a_done  <= ~r_sel_b;
                    b_done  <= r_sel_b;
                    if (!r_cmd_we) begin
                        if (r_sel_b) begin
                            b_rdata <= ram_out;
                        end else begin
                            a_rdata <= ram_out;
                        end
                    end
                end
`ifdef RAM_ARB_CLEAR_EN
                c_st_clear: begin
                    if (r_cmd_addr == c_last_addr) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_cmd_addr <= r_cmd_addr + ADDR_W'(1);
                    end
                end
`endif
                default: r_state <= c_st_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ram_arbiter                                                |
// | Brief    : Scoreboard bench for ram_arbiter with a behavioural RAM.      |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ram_arbiter;

    localparam int c_w  = 16;
    localparam int c_n  = 8;
    localparam int c_aw = 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [c_aw-1:0] a_addr = '0, b_addr = '0;
    logic [c_w-1:0]  a_wdata = '0, b_wdata = '0;
    logic            a_gnt, a_done, b_gnt, b_done;
    logic [c_w-1:0]  a_rdata, b_rdata;
    logic [c_w-1:0]  ram_in, ram_out;
    logic            ram_load, init_busy;
    logic [c_aw-1:0] ram_address;

    ram_arbiter #(.REG_W(c_w), .REG_N(c_n), .ADDR_W(c_aw)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_done(a_done), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_done(b_done), .b_rdata(b_rdata),
        .ram_in(ram_in), .ram_load(ram_load), .ram_address(ram_address),
        .ram_out(ram_out), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM: synchronous write, combinational read.
    logic [c_w-1:0] ram [c_n];
    assign ram_out = ram[ram_address];
    always @(posedge clk) if (ram_load) ram[ram_address] <= ram_in;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, per-port read data, expected responses.
    logic [c_w-1:0] m_mem [c_n];
    logic [c_w-1:0] m_rd_a = '0, m_rd_b = '0;
    logic [c_w-1:0] exp_a_q[$], exp_b_q[$];
    int             gnt_log[$];

    // Cycle-level arbitration rule: one decision slot, then one busy slot.
    logic m_slot = 1'b0, m_last_b = 1'b1, m_win_b = 1'b0;
    logic ra, rb, busy_pre, e_ga, e_gb, e_da, e_db;
    logic [c_w-1:0] exp_d;

    always @(posedge clk) begin
        ra = a_req; rb = b_req; busy_pre = init_busy;
        e_ga = 1'b0; e_gb = 1'b0; e_da = 1'b0; e_db = 1'b0;
        if (!rst_n) begin
            m_slot = 1'b0; m_last_b = 1'b1;
        end else if (m_slot) begin
            m_slot = 1'b0; e_da = !m_win_b; e_db = m_win_b;
        end else if (!busy_pre && (ra || rb)) begin
            m_win_b  = rb && (!ra || !m_last_b);
            m_last_b = m_win_b;
            m_slot   = 1'b1;
            e_ga = !m_win_b; e_gb = m_win_b;
        end
        #1;
        chk("a_gnt", a_gnt, e_ga);
        chk("b_gnt", b_gnt, e_gb);
        chk("a_done", a_done, e_da);
        chk("b_done", b_done, e_db);
        if (a_gnt) gnt_log.push_back(0);
        if (b_gnt) gnt_log.push_back(1);
        if (a_done) begin
            if (exp_a_q.size() == 0) chk("a_done_unexpected", 1, 0);
            else begin exp_d = exp_a_q.pop_front(); chk("a_rdata", a_rdata, exp_d); end
        end
        if (b_done) begin
            if (exp_b_q.size() == 0) chk("b_done_unexpected", 1, 0);
            else begin exp_d = exp_b_q.pop_front(); chk("b_rdata", b_rdata, exp_d); end
        end
    end

    // Issue one command; expected response is queued once it is granted.
    task automatic a_cmd(input logic we, input logic [c_aw-1:0] ad, input logic [c_w-1:0] wd);
        int n = 0;
        a_we = we; a_addr = ad; a_wdata = wd; a_req = 1'b1;
        do begin @(posedge clk); #2; n++; end while (!a_gnt && n < 20);
        if (!a_gnt) chk("a_gnt_timeout", 0, 1);
        else begin
            chk("a_load", ram_load, we);
            chk("a_ram_addr", ram_address, ad);
            if (we) begin chk("a_ram_in", ram_in, wd); m_mem[ad] = wd; end
            else m_rd_a = m_mem[ad];
            exp_a_q.push_back(m_rd_a);
        end
        a_req = 1'b0;
    endtask

    task automatic b_cmd(input logic we, input logic [c_aw-1:0] ad, input logic [c_w-1:0] wd);
        int n = 0;
        b_we = we; b_addr = ad; b_wdata = wd; b_req = 1'b1;
        do begin @(posedge clk); #2; n++; end while (!b_gnt && n < 20);
        if (!b_gnt) chk("b_gnt_timeout", 0, 1);
        else begin
            chk("b_load", ram_load, we);
            chk("b_ram_addr", ram_address, ad);
            if (we) begin chk("b_ram_in", ram_in, wd); m_mem[ad] = wd; end
            else m_rd_b = m_mem[ad];
            exp_b_q.push_back(m_rd_b);
        end
        b_req = 1'b0;
    endtask

    task automatic wait_clear();
`ifdef RAM_ARB_CLEAR_EN
        int n = 0;
        while (n < 40 && (n == 0 || init_busy)) begin @(posedge clk); #1; n++; end
        if (init_busy) chk("clear_timeout", 0, 1);
        for (int i = 0; i < c_n; i++) m_mem[i] = '0;
`endif
        @(posedge clk); #2;
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        m_rd_a = '0; m_rd_b = '0;
        @(negedge clk); rst_n = 1'b1;
        wait_clear();
    endtask

    task automatic rand_port(input bit is_b);
        logic [c_aw-1:0] ad;
        logic [c_w-1:0]  wd;
        for (int i = 0; i < 4; i++) begin
            ad = c_aw'(is_b ? i + 4 : i);
            wd = c_w'($urandom);
            if (is_b) b_cmd(1'b1, ad, wd); else a_cmd(1'b1, ad, wd);
        end
        for (int i = 0; i < 25; i++) begin
            ad = c_aw'($urandom_range(0, 3) + (is_b ? 4 : 0));
            wd = c_w'($urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #2;
            if (is_b) b_cmd(1'($urandom), ad, wd); else a_cmd(1'($urandom), ad, wd);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_a_gnt", a_gnt, 0);      chk("rst_b_gnt", b_gnt, 0);
        chk("rst_a_done", a_done, 0);    chk("rst_b_done", b_done, 0);
        chk("rst_a_rdata", a_rdata, 0);  chk("rst_b_rdata", b_rdata, 0);
        chk("rst_ram_load", ram_load, 0);
        chk("rst_ram_address", ram_address, 0);
        chk("rst_ram_in", ram_in, 0);
        chk("rst_init_busy", init_busy, 0);
        @(negedge clk); rst_n = 1'b1;
        wait_clear();

        // Single write, then a read of the same word from the other port.
        a_cmd(1'b1, 3'd3, 16'h1234);
        repeat (2) @(posedge clk); #2;
        chk("ram_word3", ram[3], 16'h1234);
        b_cmd(1'b0, 3'd3, 16'h0);
        repeat (2) @(posedge clk); #2;

        // Simultaneous requests: A writes, B reads the same word afterwards.
        fork
            a_cmd(1'b1, 3'd0, 16'h00AA);
            b_cmd(1'b0, 3'd0, 16'h0);
        join
        repeat (2) @(posedge clk); #2;

        // Both ports hold req across six transactions.
        do_reset();
        gnt_log.delete();
        fork
            begin a_cmd(1'b0, 3'd3, 0); a_cmd(1'b0, 3'd0, 0); a_cmd(1'b0, 3'd3, 0); end
            begin b_cmd(1'b0, 3'd0, 0); b_cmd(1'b0, 3'd3, 0); b_cmd(1'b0, 3'd0, 0); end
        join
        repeat (2) @(posedge clk); #2;
        chk("gnt_count", gnt_log.size(), 6);
        for (int i = 0; i < gnt_log.size() && i < 6; i++) chk("gnt_order", gnt_log[i], i % 2);

        // Reset in the middle of an ACCESS write.
        a_cmd(1'b1, 3'd5, 16'h0505);
        repeat (2) @(posedge clk); #2;
        a_we = 1'b1; a_addr = 3'd5; a_wdata = 16'hFFFF; a_req = 1'b1;
        @(posedge clk); #1;
        chk("abort_gnt", a_gnt, 1);
        chk("abort_load_before", ram_load, 1);
        #2;
        rst_n = 1'b0; a_req = 1'b0;
        #1;
        chk("abort_load", ram_load, 0);
        chk("abort_a_gnt", a_gnt, 0);
        chk("abort_a_rdata", a_rdata, 0);
        chk("abort_ram_address", ram_address, 0);
        chk("abort_ram_in", ram_in, 0);
        @(posedge clk); #1;
        chk("abort_word5", ram[5], 16'h0505);
        m_rd_a = '0; m_rd_b = '0;
        @(negedge clk); rst_n = 1'b1;
        wait_clear();

        // Randomized traffic, A on words 0..3 and B on words 4..7.
        fork
            rand_port(1'b0);
            rand_port(1'b1);
        join
        repeat (4) @(posedge clk); #2;

`ifdef RAM_ARB_CLEAR_EN
        rst_n = 1'b0;
        for (int i = 0; i < c_n; i++) ram[i] = 16'h5555;
        a_we = 1'b0; a_addr = 3'd2; a_req = 1'b1;
        m_rd_a = '0; m_rd_b = '0;
        @(negedge clk); rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin @(posedge clk); #1; if (init_busy) n++; end
        chk("clear_cycles", n, c_n);
        for (int i = 0; i < c_n; i++) m_mem[i] = '0;
        #1;
        a_cmd(1'b0, 3'd2, 16'h0);
        repeat (2) @(posedge clk); #2;
`endif

        n = exp_a_q.size() + exp_b_q.size();
        chk("queues_drained", n, 0);
        for (int i = 0; i < c_n; i++) chk("ram_final", ram[i], m_mem[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of one single-port `RAM` instance (REG_W-bit words, REG_N entries).
- The RAM has a synchronous write (`load` at posedge) and a combinational read (`out` follows `address`).
- Requester A (CPU data port) and requester B (screen/DMA reader) share the RAM through a registered req/gnt/done handshake.

Parameters:
- REG_W, 16, data word width; must match the RAM instance.
- REG_N, 8, number of RAM words; must match the RAM instance.
- ADDR_W, $clog2(REG_N), address width (3 at default).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a_req  in  1  requester A command valid; held high until a_gnt is seen
- a_we  in  1  A command: 1 = write, 0 = read
- a_addr  in  ADDR_W  A word address
- a_wdata  in  REG_W  A write data
- a_gnt  out  1  A command accepted (one-cycle pulse)
- a_done  out  1  A transaction complete (one-cycle pulse)
- a_rdata  out  REG_W  A read data; valid when a_done follows a read
- b_req, b_we, b_addr, b_wdata, b_gnt, b_done, b_rdata: identical set for requester B
- ram_in  out  REG_W  to RAM `in`
- ram_load  out  1  to RAM `load`
- ram_address  out  ADDR_W  to RAM `address`
- ram_out  in  REG_W  from RAM `out`
- init_busy  out  1  high while the clear sequence runs (Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values while rst_n=0: state IDLE (CLEAR when the feature is compiled in), a_gnt=b_gnt=0, a_done=b_done=0, a_rdata=b_rdata=0, ram_load=0, ram_address=0, ram_in=0, init_busy=0, last-served pointer = B (so A wins the first tie).
- State machine:
  - IDLE: at posedge, if any req is high, pick a winner, latch its we/addr/wdata into the cmd registers, go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: lasts exactly one cycle; always returns to IDLE.
- Arbitration (IDLE only):
  - Only one req high: that requester wins.
  - Both high: the requester not served last wins.
  - The last-served pointer updates on entry to ACCESS.
- Outputs during ACCESS:
  - ram_address = cmd_addr; ram_in = cmd_wdata; ram_load = cmd_we.
  - ram_load is combinational from the state and cmd registers, and is 0 in every other state.
  - The winner's gnt is high for exactly this cycle.
- At the posedge ending ACCESS:
  - A write commits into the RAM.
  - For a read, ram_out is captured into the winner's rdata.
  - The winner's done is high for the following cycle.
  - rdata holds its value until that port's next read completes; a write leaves rdata unchanged.
- Latency and throughput:
  - req to gnt: 1 cycle; req to done: 2 cycles.
  - Maximum throughput: one transaction per 2 cycles.
  - Back-to-back requests alternate A, B, A, B.
- Requester rule: req, we, addr and wdata stay stable from req rise until the cycle gnt is seen. A requester wanting a single access drops req by the next cycle. req still high in IDLE is a new request.
- Idle RAM outputs: outside ACCESS, ram_address and ram_in hold their last values; ram_load=0.
- Reset mid-ACCESS: ram_load falls immediately, so the write does not commit. No gnt or done is generated afterwards; the requester must reissue the command.

Optional Feature:
- Macro: RAM_ARB_CLEAR_EN.
- Defined:
  - After rst_n deasserts, the FSM sits in CLEAR for REG_N cycles, writing 0 to addresses 0..REG_N-1 in ascending order (ram_load=1, ram_in=0, ram_address = counter).
  - init_busy=1 throughout CLEAR; reqs are ignored and no gnt is issued.
  - CLEAR then goes to IDLE. A reset during CLEAR restarts the sequence at address 0.
- Undefined: no CLEAR state; init_busy is tied 0; IDLE directly after reset.

Test Plan:
- Reset, then A write addr 3 data 0x1234 -> a_gnt 1 cycle after req; ram_load=1 with ram_address=3 in that cycle; a_done the next cycle; RAM word 3 = 0x1234.
- B read addr 3 after the previous test -> b_done 2 cycles after req, b_rdata=0x1234; a_rdata unchanged.
- A and B both request in the same cycle after reset (A write addr 0 = 0x00AA, B read addr 0) -> A served first, then B; b_rdata=0x00AA; gnts 2 cycles apart.
- A and B hold req continuously for 6 transactions -> grant order A, B, A, B, A, B; never two gnts in one cycle.
- Assert rst_n=0 during A's ACCESS write of 0xFFFF to addr 5 -> ram_load drops at once; word 5 keeps its old value; no a_done; all outputs at reset values.
- With RAM_ARB_CLEAR_EN: preload RAM with 0x5555 and release reset with a_req high -> init_busy high for 8 cycles; all 8 words read back 0; first a_gnt only after init_busy falls.
